// File: rtl/spram_32x4096_cb.sv
// Single-port synchronous SRAM model, 4096 x 32, active-low CSB/WEB/OEB, 1-edge read latency.
// Reset clears only the output latch; stored words survive reset and are never initialised.
module spram_32x4096_cb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  gbdt_clk,
  input  logic                  gbdt_rst_n,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] I,
  input  logic                  CSB,
  input  logic                  WEB,
  input  logic                  OEB,
  output logic [DATA_WIDTH-1:0] O
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  ctrl_x;
  logic                  wr_maybe;
  logic                  rd_maybe;

  // Unknown controls poison whichever access they could have enabled.
  always_comb begin
    ctrl_x   = $isunknown({CSB, WEB});
    wr_maybe = (CSB !== 1'b1) && (WEB !== 1'b1);
    rd_maybe = (CSB !== 1'b1) && (WEB !== 1'b0);
  end

  // Writes are blocked while reset is low, so mem shares this process without being reset.
  always_ff @(posedge gbdt_clk or negedge gbdt_rst_n) begin
    if (!gbdt_rst_n) begin
      dout_q <= '0;
    end else if (ctrl_x) begin
      if (wr_maybe) mem[A] <= {DATA_WIDTH{1'bx}};
      if (rd_maybe) dout_q <= {DATA_WIDTH{1'bx}};
    end else if (!CSB) begin
      if (!WEB) mem[A] <= I;
      else      dout_q <= mem[A];
    end
  end

  assign O = OEB ? {DATA_WIDTH{1'bz}} : dout_q;

endmodule

// File: tb/tb_spram_32x4096_cb.sv
// Directed bench for spram_32x4096_cb; O has weak pull-ups so a released bus reads all ones.
module tb_spram_32x4096_cb;

  logic        gbdt_clk;
  logic        gbdt_rst_n;
  logic [11:0] A;
  logic [31:0] I;
  logic        CSB;
  logic        WEB;
  logic        OEB;
  wire  [31:0] o_w;

  int n_vec;
  int n_err;

  localparam logic [31:0] PULLED = 32'hFFFF_FFFF;

  spram_32x4096_cb dut (
    .gbdt_clk   (gbdt_clk),
    .gbdt_rst_n (gbdt_rst_n),
    .A          (A),
    .I          (I),
    .CSB        (CSB),
    .WEB        (WEB),
    .OEB        (OEB),
    .O          (o_w)
  );

  for (genvar g = 0; g < 32; g++) begin : g_pu
    pullup pu (o_w[g]);
  end

  initial gbdt_clk = 1'b0;
  always #5 gbdt_clk = ~gbdt_clk;

  // Apply one access, then sample 1 time unit after the capturing edge.
  task automatic access(input logic csb, input logic web, input logic [11:0] a,
                        input logic [31:0] d);
    CSB = csb;
    WEB = web;
    A   = a;
    I   = d;
    @(posedge gbdt_clk);
    #1;
  endtask

  task automatic test_reset();
    gbdt_rst_n = 1'b0;
    OEB = 1'b0;
    CSB = 1'b1;
    WEB = 1'b1;
    A   = '0;
    I   = '0;
    #2;
    n_vec++;
    if (o_w !== 32'h0) begin
      n_err++;
      $display("FAIL reset_o: got %h want %h", o_w, 32'h0);
    end
    @(negedge gbdt_clk);
    gbdt_rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      access(1'b1, 1'b1, 12'h000, 32'h0);
      n_vec++;
      if (o_w !== 32'h0) begin
        n_err++;
        $display("FAIL idle_%0d: got %h want %h", k, o_w, 32'h0);
      end
    end
  endtask

  task automatic test_addr_ends();
    access(1'b0, 1'b0, 12'h000, 32'hDEAD_BEEF);
    access(1'b0, 1'b0, 12'hFFF, 32'h1234_5678);
    n_vec++;
    if (o_w !== 32'h0) begin
      n_err++;
      $display("FAIL write_no_dout: got %h want %h", o_w, 32'h0);
    end
    access(1'b0, 1'b1, 12'h000, 32'h0);
    n_vec++;
    if (o_w !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL read_a000: got %h want %h", o_w, 32'hDEAD_BEEF);
    end
    access(1'b0, 1'b1, 12'hFFF, 32'h0);
    n_vec++;
    if (o_w !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL read_afff: got %h want %h", o_w, 32'h1234_5678);
    end
  endtask

  task automatic test_no_write_through();
    access(1'b0, 1'b0, 12'h005, 32'hA5A5_A5A5);
    access(1'b0, 1'b1, 12'h005, 32'h0);
    n_vec++;
    if (o_w !== 32'hA5A5_A5A5) begin
      n_err++;
      $display("FAIL read_a005: got %h want %h", o_w, 32'hA5A5_A5A5);
    end
    access(1'b0, 1'b0, 12'h005, 32'h0F0F_0F0F);
    n_vec++;
    if (o_w !== 32'hA5A5_A5A5) begin
      n_err++;
      $display("FAIL no_write_through: got %h want %h", o_w, 32'hA5A5_A5A5);
    end
    access(1'b0, 1'b1, 12'h005, 32'h0);
    n_vec++;
    if (o_w !== 32'h0F0F_0F0F) begin
      n_err++;
      $display("FAIL reread_a005: got %h want %h", o_w, 32'h0F0F_0F0F);
    end
  endtask

  task automatic test_oeb();
    OEB = 1'b1;
    access(1'b0, 1'b1, 12'h000, 32'h0);
    n_vec++;
    if (o_w !== PULLED) begin
      n_err++;
      $display("FAIL oeb_hiz: got %h want released %h", o_w, PULLED);
    end
    OEB = 1'b0;
    #1;
    n_vec++;
    if (o_w !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL oeb_enable: got %h want %h", o_w, 32'hDEAD_BEEF);
    end
    OEB = 1'b1;
    #1;
    n_vec++;
    if (o_w !== PULLED) begin
      n_err++;
      $display("FAIL oeb_release: got %h want released %h", o_w, PULLED);
    end
    OEB = 1'b0;
  endtask

  task automatic test_csb_blocks();
    access(1'b0, 1'b0, 12'h010, 32'h2222_2222);
    access(1'b1, 1'b0, 12'h010, 32'hFFFF_FFFF);
    n_vec++;
    if (o_w !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL csb_hold_dout: got %h want %h", o_w, 32'hDEAD_BEEF);
    end
    access(1'b1, 1'b1, 12'h010, 32'h0);
    n_vec++;
    if (o_w !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL csb_no_read: got %h want %h", o_w, 32'hDEAD_BEEF);
    end
    access(1'b0, 1'b1, 12'h010, 32'h0);
    n_vec++;
    if (o_w !== 32'h2222_2222) begin
      n_err++;
      $display("FAIL csb_no_write: got %h want %h", o_w, 32'h2222_2222);
    end
  endtask

  task automatic test_back_to_back();
    access(1'b0, 1'b0, 12'h100, 32'hCAFE_0001);
    access(1'b0, 1'b1, 12'h100, 32'h0);
    n_vec++;
    if (o_w !== 32'hCAFE_0001) begin
      n_err++;
      $display("FAIL wr_then_rd: got %h want %h", o_w, 32'hCAFE_0001);
    end
    access(1'b0, 1'b0, 12'h100, 32'hCAFE_0002);
    access(1'b0, 1'b1, 12'h800, 32'h0);
    access(1'b0, 1'b1, 12'h100, 32'h0);
    n_vec++;
    if (o_w !== 32'hCAFE_0002) begin
      n_err++;
      $display("FAIL rd_after_rewrite: got %h want %h", o_w, 32'hCAFE_0002);
    end
  endtask

  task automatic test_reset_mid();
    access(1'b0, 1'b0, 12'h020, 32'h1111_1111);
    access(1'b0, 1'b1, 12'h020, 32'h0);
    n_vec++;
    if (o_w !== 32'h1111_1111) begin
      n_err++;
      $display("FAIL pre_reset_read: got %h want %h", o_w, 32'h1111_1111);
    end
    #1;
    gbdt_rst_n = 1'b0;
    #1;
    n_vec++;
    if (o_w !== 32'h0) begin
      n_err++;
      $display("FAIL async_clear: got %h want %h", o_w, 32'h0);
    end
    access(1'b0, 1'b0, 12'h020, 32'hBAD0_BAD0);
    access(1'b0, 1'b1, 12'h020, 32'h0);
    n_vec++;
    if (o_w !== 32'h0) begin
      n_err++;
      $display("FAIL reset_blocks_read: got %h want %h", o_w, 32'h0);
    end
    gbdt_rst_n = 1'b1;
    access(1'b0, 1'b1, 12'h020, 32'h0);
    n_vec++;
    if (o_w !== 32'h1111_1111) begin
      n_err++;
      $display("FAIL mem_survives_reset: got %h want %h", o_w, 32'h1111_1111);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_addr_ends();
    test_no_write_through();
    test_oeb();
    test_csb_blocks();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
